decode_stage: RTL

- ID stage of the 5-stage RV32I pipeline.
- Consumes the fetch stage's D-side outputs (InstrD, PCD, PCPlus4D) and decodes the instruction.
- Reads the 32x32 register file, which is written from the writeback stage, and generates the sign-extended immediate.
- Registers everything into the ID/EX pipeline register, which feeds the execute stage that returns PCSrcE/PCTargetE to fetch.

---
 rtl/decode_stage_pkg.sv | 74 +++++++
 rtl/decode_stage_register_file.sv | 54 +++++
 rtl/decode_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// Shared constants, decode encodings and the ID/EX pipeline record for the RV32I decode stage.
// Also hosts the immediate generator so any stage can reuse the same format rules.
package decode_stage_pkg;

    localparam int WORD_SIZE = 32;
    localparam int REG_COUNT = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [WORD_SIZE-1:0] PC_INITIAL = '0;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_J    = 3'd4
    } imm_src_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic                 reg_write;
        logic [1:0]           result_src;
        logic                 mem_write;
        logic                 jump;
        logic                 branch;
        logic [2:0]           alu_control;
        logic                 alu_src;
        logic                 illegal;
        logic [WORD_SIZE-1:0] rd1;
        logic [WORD_SIZE-1:0] rd2;
        logic [WORD_SIZE-1:0] imm_ext;
        logic [WORD_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] pc_plus4;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
    } id_ex_t;

    function automatic logic [WORD_SIZE-1:0] imm_extend(input logic [31:0] instr,
                                                        input imm_src_e imm_src);
        logic [WORD_SIZE-1:0] imm;
        case (imm_src)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// 32-entry register file: two combinational read ports with write-through bypass,
// one synchronous write port, x0 hardwired to zero, synchronous clear on reset.
module register_file
    import decode_stage_pkg::*;
#(
    parameter int WORD_SIZE = decode_stage_pkg::WORD_SIZE,
    parameter int REG_COUNT = decode_stage_pkg::REG_COUNT,
    parameter int IDX_W     = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     raddr1,
    input  logic [IDX_W-1:0]     raddr2,
    output logic [WORD_SIZE-1:0] rdata1,
    output logic [WORD_SIZE-1:0] rdata2,
    input  logic                 we,
    input  logic [IDX_W-1:0]     waddr,
    input  logic [WORD_SIZE-1:0] wdata
);

    logic [REG_COUNT-1:0][WORD_SIZE-1:0] regs_q;
    logic [REG_COUNT-1:0][WORD_SIZE-1:0] regs_d;
    logic                                write_en;

    assign write_en = we && (waddr != '0);

    always_comb begin
        regs_d = regs_q;
        if (write_en) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass lets writeback and a dependent decode share the same cycle.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) begin
            rdata1 = (write_en && waddr == raddr1) ? wdata : regs_q[raddr1];
        end
        if (raddr2 != '0) begin
            rdata2 = (write_en && waddr == raddr2) ? wdata : regs_q[raddr2];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: decodes InstrD, reads the register file, builds the immediate
// and registers everything into the ID/EX pipeline register.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int WORD_SIZE = decode_stage_pkg::WORD_SIZE,
    parameter int REG_COUNT = decode_stage_pkg::REG_COUNT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  InstrD,
    input  logic [WORD_SIZE-1:0]         PCD,
    input  logic [WORD_SIZE-1:0]         PCPlus4D,
    input  logic                         FlushE,
    input  logic                         RegWriteW,
    input  logic [$clog2(REG_COUNT)-1:0] RdW,
    input  logic [WORD_SIZE-1:0]         ResultW,
    output logic                         RegWriteE,
    output logic [1:0]                   ResultSrcE,
    output logic                         MemWriteE,
    output logic                         JumpE,
    output logic                         BranchE,
    output logic [2:0]                   ALUControlE,
    output logic                         ALUSrcE,
    output logic                         IllegalE,
    output logic [WORD_SIZE-1:0]         RD1E,
    output logic [WORD_SIZE-1:0]         RD2E,
    output logic [WORD_SIZE-1:0]         ImmExtE,
    output logic [WORD_SIZE-1:0]         PCE,
    output logic [WORD_SIZE-1:0]         PCPlus4E,
    output logic [$clog2(REG_COUNT)-1:0] Rs1E,
    output logic [$clog2(REG_COUNT)-1:0] Rs2E,
    output logic [$clog2(REG_COUNT)-1:0] RdE
);

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic [REG_IDX_W-1:0] rs1, rs2, rd;

    logic                 reg_write, mem_write, jump, branch, alu_src, illegal;
    logic [1:0]           result_src;
    logic [2:0]           alu_control;
    imm_src_e             imm_src;
    alu_op_e              alu_op;
    logic [WORD_SIZE-1:0] rd1, rd2;

    id_ex_t id_ex_d, id_ex_q;

    assign opcode   = InstrD[6:0];
    assign rd       = InstrD[11:7];
    assign funct3   = InstrD[14:12];
    assign rs1      = InstrD[19:15];
    assign rs2      = InstrD[24:20];
    assign funct7b5 = InstrD[30];

    register_file #(
        .WORD_SIZE (WORD_SIZE),
        .REG_COUNT (REG_COUNT)
    ) u_register_file (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rd1),
        .rdata2 (rd2),
        .we     (RegWriteW),
        .waddr  (RdW),
        .wdata  (ResultW)
    );

    always_comb begin
        reg_write   = 1'b0;
        result_src  = RES_ALU;
        mem_write   = 1'b0;
        jump        = 1'b0;
        branch      = 1'b0;
        alu_src     = 1'b0;
        imm_src     = IMM_NONE;
        alu_op      = ALUOP_ADD;
        illegal     = 1'b0;
        alu_control = ALU_ADD;

        case (opcode)
            OP_R:   begin reg_write = 1'b1; alu_op = ALUOP_FUNCT; end
            OP_I:   begin reg_write = 1'b1; alu_src = 1'b1; imm_src = IMM_I; alu_op = ALUOP_FUNCT; end
            OP_LW:  begin reg_write = 1'b1; result_src = RES_MEM; alu_src = 1'b1; imm_src = IMM_I; end
            OP_SW:  begin mem_write = 1'b1; alu_src = 1'b1; imm_src = IMM_S; end
            OP_BEQ: begin branch = 1'b1; imm_src = IMM_B; alu_op = ALUOP_SUB; end
            OP_JAL: begin reg_write = 1'b1; result_src = RES_PC4; jump = 1'b1; imm_src = IMM_J; end
            // All-zero opcode is the post-reset fetch bubble, not an illegal instruction.
            default: illegal = (opcode != 7'b0000000);
        endcase

        case (alu_op)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: begin
                        alu_control = ALU_ADD;
                        illegal     = 1'b1;
                    end
                endcase
            end
            default:     alu_control = ALU_ADD;
        endcase
    end

    always_comb begin
        id_ex_d = '0;
        if (!FlushE) begin
            id_ex_d.reg_write   = reg_write;
            id_ex_d.result_src  = result_src;
            id_ex_d.mem_write   = mem_write;
            id_ex_d.jump        = jump;
            id_ex_d.branch      = branch;
            id_ex_d.alu_control = alu_control;
            id_ex_d.alu_src     = alu_src;
            id_ex_d.illegal     = illegal;
            id_ex_d.rd1         = rd1;
            id_ex_d.rd2         = rd2;
            id_ex_d.imm_ext     = imm_extend(InstrD, imm_src);
            id_ex_d.pc          = PCD;
            id_ex_d.pc_plus4    = PCPlus4D;
            id_ex_d.rs1         = rs1;
            id_ex_d.rs2         = rs2;
            id_ex_d.rd          = rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign RegWriteE   = id_ex_q.reg_write;
    assign ResultSrcE  = id_ex_q.result_src;
    assign MemWriteE   = id_ex_q.mem_write;
    assign JumpE       = id_ex_q.jump;
    assign BranchE     = id_ex_q.branch;
    assign ALUControlE = id_ex_q.alu_control;
    assign ALUSrcE     = id_ex_q.alu_src;
    assign IllegalE    = id_ex_q.illegal;
    assign RD1E        = id_ex_q.rd1;
    assign RD2E        = id_ex_q.rd2;
    assign ImmExtE     = id_ex_q.imm_ext;
    assign PCE         = id_ex_q.pc;
    assign PCPlus4E    = id_ex_q.pc_plus4;
    assign Rs1E        = id_ex_q.rs1;
    assign Rs2E        = id_ex_q.rs2;
    assign RdE         = id_ex_q.rd;

endmodule
